// File: rtl/add_arbiter_pkg.sv
// Shared types and limits for the add_arbiter round-robin adder sequencer.
// Build option: ADD_ARBITER_OVF_EN adds the registered signed-overflow output.
package add_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    localparam int N_REQ_MAX = 8;
    localparam int WIDTH_DEF = 32;

endpackage

// File: rtl/add_16.sv
// Ripple-carry adder slice; two of these chained form the shared wide adder.
module add_16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo N_REQ.
module add_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   grant,
    output logic             any
);

    logic [IDW-1:0] idx;

    // Scan from farthest to nearest so the nearest valid entry wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (valid[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one ripple adder among N_REQ requesters.
// Build option: ADD_ARBITER_OVF_EN adds the rsp_ovf output port.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]         req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout
`ifdef ADD_ARBITER_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);

    localparam int IDW = $clog2(N_REQ);
    localparam int LO  = WIDTH / 2;
    localparam int HI  = WIDTH - LO;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   next_ptr;
    logic             any;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] sum;
    logic             c_mid;
    logic             cout;

    add_arbiter_rr #(
        .N_REQ(N_REQ),
        .IDW  (IDW)
    ) u_rr (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .any  (any)
    );

    add_16 #(.W(LO)) u_add_lo (
        .a   (a_q[LO-1:0]),
        .b   (b_q[LO-1:0]),
        .cin (cin_q),
        .sum (sum[LO-1:0]),
        .cout(c_mid)
    );

    add_16 #(.W(HI)) u_add_hi (
        .a   (a_q[WIDTH-1:LO]),
        .b   (b_q[WIDTH-1:LO]),
        .cin (c_mid),
        .sum (sum[WIDTH-1:LO]),
        .cout(cout)
    );

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && any)
            req_ready[grant] = 1'b1;
    end

    assign next_ptr = (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
`ifdef ADD_ARBITER_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        a_q    <= req_a[int'(grant)*WIDTH +: WIDTH];
                        b_q    <= req_b[int'(grant)*WIDTH +: WIDTH];
                        cin_q  <= req_cin[grant];
                        id_q   <= grant;
                        rr_ptr <= next_ptr;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum;
                    rsp_cout  <= cout;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
`ifdef ADD_ARBITER_OVF_EN
                    rsp_ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized and directed bench for add_arbiter against a transaction-level
// model: a queue of accepted requests, each due two cycles after its accept.
module tb_add_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int           id;
        logic [W:0]   s;
        logic         ovf;
        int           due;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     vld;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     a_r [N];
    logic [W-1:0]     b_r [N];
    logic [N-1:0]     cin_r;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
`ifdef ADD_ARBITER_OVF_EN
    logic             rsp_ovf;
`endif

    rsp_t q[$];
    rsp_t shown;
    int   ptr;
    int   cyc;
    int   last_g;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_r[i];
            req_b[i*W +: W] = b_r[i];
        end
    end

    add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(vld),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (cin_r),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout)
`ifdef ADD_ARBITER_OVF_EN
        ,
        .rsp_ovf  (rsp_ovf)
`endif
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 5)
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: check outputs against the model, then advance it at the edge.
    task automatic cycle();
        int      g;
        logic    ev;
        logic    hs;
        logic [N-1:0] er;
        rsp_t    r;
        #2;
        g  = (rst || q.size() != 0) ? -1 : pick(vld, ptr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        ev = (q.size() != 0) && (cyc >= q[0].due);
        if (ev) shown = q[0];
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        check("rsp_id", 64'(rsp_id), 64'(shown.id));
        check("rsp_sum_cout", {31'd0, rsp_cout, rsp_sum}, 64'(shown.s));
`ifdef ADD_ARBITER_OVF_EN
        check("rsp_ovf", 64'(rsp_ovf), 64'(shown.ovf));
`endif
        hs = ev && rsp_ready;
        if (g >= 0) begin
            r.id  = g;
            r.s   = {1'b0, a_r[g]} + {1'b0, b_r[g]} + (W+1)'(cin_r[g]);
            r.ovf = (a_r[g][W-1] == b_r[g][W-1]) && (r.s[W-1] != a_r[g][W-1]);
            r.due = cyc + 2;
        end
        @(posedge clk);
        last_g = -1;
        if (rst) begin
            q.delete();
            ptr   = 0;
            shown = '{0, '0, 1'b0, 0};
        end else begin
            if (hs) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(r);
                ptr    = (g + 1) % N;
                last_g = g;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic c);
        a_r[i]   = a;
        b_r[i]   = b;
        cin_r[i] = c;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            if (vld[i] && last_g == i) begin
                set_req(i, rnd_op(), rnd_op(), 1'($urandom));
                vld[i] = 1'($urandom);
            end else if (vld[i]) begin
                if ($urandom % 8 == 0) vld[i] = 1'b0;
            end else if ($urandom % 3 == 0) begin
                set_req(i, rnd_op(), rnd_op(), 1'($urandom));
                vld[i] = 1'b1;
            end
        end
        rsp_ready = ($urandom % 4) != 0;
        rst       = ($urandom % 150) == 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ptr     = 0;
        cyc     = 0;
        last_g  = -1;
        shown   = '{0, '0, 1'b0, 0};
        rst     = 1'b1;
        vld     = '0;
        cin_r   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single request from requester 2
        vld = 4'b0100;
        set_req(2, 32'h5, 32'h3, 1'b1);
        #1 check("single_grant", 64'(req_ready), 64'b0100);
        cycle();
        vld = '0;
        cycle();
        #1;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_sum", 64'(rsp_sum), 64'h9);
        check("single_cout", 64'(rsp_cout), 64'd0);
        check("single_id", 64'(rsp_id), 64'd2);
        cycle();

        // Wrap-around (ptr = 3, only requester 1) with a full carry
        vld = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1 check("wrap_grant", 64'(req_ready), 64'b0010);
        cycle();
        vld = '0;
        cycle();
        #1;
        check("carry_sum", 64'(rsp_sum), 64'h0);
        check("carry_cout", 64'(rsp_cout), 64'd1);
        check("carry_id", 64'(rsp_id), 64'd1);
        cycle();
        vld = 4'b1111;
        #1 check("wrap_ptr_is_2", 64'(req_ready), 64'b0100);
        cycle();
        vld = '0;
        cycle();
        cycle();

`ifdef ADD_ARBITER_OVF_EN
        vld = 4'b0001;
        set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        cycle();
        vld = '0;
        cycle();
        #1 check("ovf_set", 64'(rsp_ovf), 64'd1);
        cycle();
`endif

        // Round robin from reset, all requesters held valid
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op(), 1'($urandom));
        vld = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_order", 64'(req_ready), 64'(1 << (k % N)));
            cycle();
            cycle();
            cycle();
        end
        vld = '0;
        cycle();
        cycle();
        cycle();

        // Backpressure: response held for 5 cycles, requester 3 waits
        vld = 4'b0001;
        set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        cycle();
        vld = 4'b1000;
        set_req(3, 32'hA, 32'hB, 1'b0);
        rsp_ready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) cycle();
        #1 check("bp_held_sum", 64'(rsp_sum), 64'h2345_678A);
        rsp_ready = 1'b1;
        cycle();
        #1 check("bp_next_grant", 64'(req_ready), 64'b1000);
        cycle();
        vld = '0;
        cycle();
        cycle();

        // Reset while the operation is in EXEC
        vld = 4'b0010;
        set_req(1, 32'h55, 32'h66, 1'b1);
        cycle();
        vld = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        #1;
        check("rst_exec_valid", 64'(rsp_valid), 64'd0);
        check("rst_exec_sum", 64'(rsp_sum), 64'd0);
        vld = 4'b0011;
        #1 check("rst_exec_ptr", 64'(req_ready), 64'b0001);
        cycle();
        vld = '0;
        cycle();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            randomize_inputs();
            cycle();
        end
        vld = '0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
